// File: rtl/inst_mem_sync_if.sv
// Fetch / response / program-load bundle for the synchronous instruction memory.
// master: IF stage and program loader (drives requests, stall, flush, loads).
// slave : inst_mem_sync (drives ready flags, response and busy).
interface inst_mem_sync_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic [ADDR_W-1:0] req_adrs;
  logic              req_ready;
  logic              stall;
  logic              flush;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_inst;
  logic [ADDR_W-1:0] rsp_adrs;
  logic              rsp_err;
  logic              load_en;
  logic [ADDR_W-1:0] load_adrs;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              busy;

  modport master (
    output req_valid, req_adrs, stall, flush, load_en, load_adrs, load_data,
    input  req_ready, rsp_valid, rsp_inst, rsp_adrs, rsp_err, load_ready, busy
  );

  modport slave (
    input  req_valid, req_adrs, stall, flush, load_en, load_adrs, load_data,
    output req_ready, rsp_valid, rsp_inst, rsp_adrs, rsp_err, load_ready, busy
  );
endinterface

// File: rtl/inst_mem_sync.sv
// Synchronous instruction memory for the IF stage: byte-addressed, word-aligned
// fetch with a 1-cycle registered read, stall/flush handling, a run-time
// program-load write port and a post-reset clear of every word to NOP_WORD.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - inst_mem_sync_if.slave: req_* fetch request, rsp_* response,
//          stall/flush from the pipeline, load_* program write port, busy
module inst_mem_sync #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 256,
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic           clk,
  input  logic           rst,
  inst_mem_sync_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              busy_q;
  logic              load_ready_q;

  logic              req_ready_c;
  logic              accept_c;
  logic              req_err_c;
  logic              load_err_c;
  logic [IDX_W-1:0]  req_idx_c;
  logic [IDX_W-1:0]  load_idx_c;

  logic              mem_we_c;
  logic [IDX_W-1:0]  mem_waddr_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_inst_q;
  logic [ADDR_W-1:0] rsp_adrs_q;
  logic              rsp_err_q;

  // Misaligned, or any address bit above the word index set.
  function automatic logic adrs_bad(input logic [ADDR_W-1:0] a);
    return (a[1:0] != 2'b00) || ((a >> (IDX_W + 2)) != '0);
  endfunction

  assign req_idx_c  = bus.req_adrs[IDX_W+1:2];
  assign load_idx_c = bus.load_adrs[IDX_W+1:2];
  assign req_err_c  = adrs_bad(bus.req_adrs);
  assign load_err_c = adrs_bad(bus.load_adrs);

  // State register; busy/load_ready follow the next state so they change on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_CLEAR;
      cnt_q        <= '0;
      busy_q       <= 1'b1;
      load_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      busy_q       <= (state_d == ST_CLEAR);
      load_ready_q <= (state_d == ST_RUN);
    end
  end

  // Next state, clear sequencing and the single shared write port.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_c = 1'b0;
    accept_c    = 1'b0;
    mem_we_c    = 1'b0;
    mem_waddr_c = load_idx_c;
    mem_wdata_c = bus.load_data;
    case (state_q)
      ST_CLEAR: begin
        mem_we_c    = 1'b1;
        mem_waddr_c = cnt_q;
        mem_wdata_c = NOP_WORD;
        cnt_d       = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        req_ready_c = ~bus.stall & ~bus.flush;
        accept_c    = bus.req_valid & req_ready_c;
        mem_we_c    = bus.load_en & ~load_err_c;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // Write port; no reset so the array stays RAM-inferable (clear is done by the FSM).
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[mem_waddr_c] <= mem_wdata_c;
    end
  end

  // Registered read and response; old data is read on a same-word write (read-first).
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_inst_q  <= NOP_WORD;
      rsp_adrs_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else if (bus.flush) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_inst_q  <= NOP_WORD;
    end else if (!bus.stall) begin
      if (accept_c) begin
        rsp_valid_q <= 1'b1;
        rsp_adrs_q  <= bus.req_adrs;
        rsp_err_q   <= req_err_c;
        if (req_err_c) begin
          rsp_inst_q <= NOP_WORD;
        end else begin
          rsp_inst_q <= mem[req_idx_c];
        end
      end else begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.load_ready = load_ready_q;
  assign bus.busy       = busy_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_inst   = rsp_inst_q;
  assign bus.rsp_adrs   = rsp_adrs_q;
  assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_inst_mem_sync.sv
// Self-checking bench for inst_mem_sync: an array/counter model updated at each
// rising edge, a per-cycle compare on the falling edge, and directed vectors
// with literal expectations.
module tb_inst_mem_sync;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 256;
  localparam int unsigned ADDR_W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_mem_sync_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  inst_mem_sync #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .NOP_WORD(32'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [31:0] m_mem [DEPTH];
  int          m_clear_left = 0;
  bit          m_init = 1'b0;
  bit          m_valid, m_err, m_run;
  logic [31:0] m_inst, m_adrs;

  function automatic bit bad_adrs(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'(DEPTH * 4));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_init       = 1'b1;
      m_clear_left = DEPTH;
      m_valid      = 1'b0;
      m_inst       = 32'h0;
      m_adrs       = 32'h0;
      m_err        = 1'b0;
    end else if (m_init) begin
      m_run = (m_clear_left == 0);
      if (bus.flush) begin
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_inst  = 32'h0;
      end else if (!bus.stall) begin
        if (m_run && bus.req_valid) begin
          m_valid = 1'b1;
          m_adrs  = bus.req_adrs;
          m_err   = bad_adrs(bus.req_adrs);
          m_inst  = m_err ? 32'h0 : m_mem[int'(bus.req_adrs / 4)];
        end else begin
          m_valid = 1'b0;
        end
      end
      if (!m_run) begin
        m_mem[DEPTH - m_clear_left] = 32'h0;
        m_clear_left--;
      end else if (bus.load_en && !bad_adrs(bus.load_adrs)) begin
        m_mem[int'(bus.load_adrs / 4)] = bus.load_data;
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (m_init) begin
      chk("busy", 64'(bus.busy), 64'(m_clear_left != 0));
      chk("load_ready", 64'(bus.load_ready), 64'(m_clear_left == 0));
      chk("req_ready", 64'(bus.req_ready),
          64'((m_clear_left == 0) && !bus.stall && !bus.flush));
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_valid));
      if (m_valid) begin
        chk("rsp_inst", 64'(bus.rsp_inst), 64'(m_inst));
        chk("rsp_adrs", 64'(bus.rsp_adrs), 64'(m_adrs));
        chk("rsp_err", 64'(bus.rsp_err), 64'(m_err));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 2000) begin
      cyc();
      n++;
    end
  endtask

  task automatic expect_rsp(input string nm, input bit v, input logic [31:0] inst,
                            input logic [31:0] adrs, input bit err);
    chk({nm, "_valid"}, 64'(bus.rsp_valid), 64'(v));
    if (v) begin
      chk({nm, "_inst"}, 64'(bus.rsp_inst), 64'(inst));
      chk({nm, "_adrs"}, 64'(bus.rsp_adrs), 64'(adrs));
      chk({nm, "_err"}, 64'(bus.rsp_err), 64'(err));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_adrs  = '0;
    bus.stall     = 1'b0;
    bus.flush     = 1'b0;
    bus.load_en   = 1'b0;
    bus.load_adrs = '0;
    bus.load_data = '0;
    cyc();
    chk("reset_busy", 64'(bus.busy), 64'(1));
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("reset_rsp_inst", 64'(bus.rsp_inst), 64'(0));
    chk("reset_rsp_adrs", 64'(bus.rsp_adrs), 64'(0));
    chk("reset_load_ready", 64'(bus.load_ready), 64'(0));
    rst = 1'b0;
    wait_clear(n);
    chk("clear_cycles", 64'(n), 64'(256));
    chk("req_ready_after_clear", 64'(bus.req_ready), 64'(1));

    // Cleared words read NOP.
    bus.req_valid = 1'b1; bus.req_adrs = 32'h0;   cyc(); expect_rsp("f0",   1, 32'h0, 32'h0,   0);
    bus.req_adrs = 32'h4;                         cyc(); expect_rsp("f4",   1, 32'h0, 32'h4,   0);
    bus.req_adrs = 32'h3FC;                       cyc(); expect_rsp("f3fc", 1, 32'h0, 32'h3FC, 0);
    bus.req_valid = 1'b0;                         cyc(); expect_rsp("idle", 0, 32'h0, 32'h0,   0);

    // Program load, then back-to-back fetch.
    bus.load_en = 1'b1; bus.load_adrs = 32'h4; bus.load_data = 32'h80010608; cyc();
    bus.load_adrs = 32'h8; bus.load_data = 32'h04011000;                      cyc();
    bus.load_en = 1'b0;
    bus.req_valid = 1'b1; bus.req_adrs = 32'h4; cyc(); expect_rsp("ld4", 1, 32'h80010608, 32'h4, 0);
    bus.req_adrs = 32'h8;                       cyc(); expect_rsp("ld8", 1, 32'h04011000, 32'h8, 0);

    // Stall holds the response and blocks new requests.
    bus.req_adrs = 32'h4; cyc(); expect_rsp("pre_stall", 1, 32'h80010608, 32'h4, 0);
    bus.stall = 1'b1; bus.req_adrs = 32'h8; #1;
    chk("stall_req_ready", 64'(bus.req_ready), 64'(0));
    for (int i = 0; i < 3; i++) begin
      cyc();
      expect_rsp("stall_hold", 1, 32'h80010608, 32'h4, 0);
      chk("stall_req_ready", 64'(bus.req_ready), 64'(0));
    end
    bus.stall = 1'b0; cyc(); expect_rsp("post_stall", 1, 32'h04011000, 32'h8, 0);

    // Flush beats a same-cycle request.
    bus.req_adrs = 32'hC; bus.flush = 1'b1; #1;
    chk("flush_req_ready", 64'(bus.req_ready), 64'(0));
    cyc();
    chk("flush_valid", 64'(bus.rsp_valid), 64'(0));
    chk("flush_inst", 64'(bus.rsp_inst), 64'(0));
    bus.flush = 1'b0; bus.req_valid = 1'b0; cyc();
    chk("flush_no_accept", 64'(bus.rsp_valid), 64'(0));

    // Flush while a stalled response is held.
    bus.req_valid = 1'b1; bus.req_adrs = 32'h4; cyc(); expect_rsp("fs_pre", 1, 32'h80010608, 32'h4, 0);
    bus.stall = 1'b1;                            cyc(); expect_rsp("fs_hold", 1, 32'h80010608, 32'h4, 0);
    bus.flush = 1'b1;                            cyc();
    chk("fs_valid", 64'(bus.rsp_valid), 64'(0));
    chk("fs_inst", 64'(bus.rsp_inst), 64'(0));
    chk("fs_err", 64'(bus.rsp_err), 64'(0));
    bus.flush = 1'b0; bus.stall = 1'b0; bus.req_valid = 1'b0; cyc();

    // Error fetches.
    bus.req_valid = 1'b1; bus.req_adrs = 32'h6;   cyc(); expect_rsp("mis",  1, 32'h0, 32'h6,   1);
    bus.req_adrs = 32'h400;                       cyc(); expect_rsp("oor",  1, 32'h0, 32'h400, 1);
    bus.req_valid = 1'b0;

    // Bad loads are dropped.
    bus.load_en = 1'b1; bus.load_adrs = 32'h400; bus.load_data = 32'h12345678; cyc();
    bus.load_adrs = 32'h9; bus.load_data = 32'hAAAA5555;                       cyc();
    bus.load_en = 1'b0;
    bus.req_valid = 1'b1; bus.req_adrs = 32'h0; cyc(); expect_rsp("badld0", 1, 32'h0,        32'h0, 0);
    bus.req_adrs = 32'h8;                       cyc(); expect_rsp("badld8", 1, 32'h04011000, 32'h8, 0);

    // Same-cycle load and fetch: old word first, new word on re-fetch.
    bus.load_en = 1'b1; bus.load_adrs = 32'h10; bus.load_data = 32'hDEADBEEF;
    bus.req_adrs = 32'h10;                      cyc(); expect_rsp("rf_old", 1, 32'h0,        32'h10, 0);
    bus.load_en = 1'b0;                         cyc(); expect_rsp("rf_new", 1, 32'hDEADBEEF, 32'h10, 0);

    // Reset mid-stream.
    bus.req_adrs = 32'h4; cyc(); expect_rsp("pre_rst", 1, 32'h80010608, 32'h4, 0);
    rst = 1'b1; cyc();
    chk("rst_mid_valid", 64'(bus.rsp_valid), 64'(0));
    chk("rst_mid_busy", 64'(bus.busy), 64'(1));
    rst = 1'b0; bus.req_valid = 1'b0;
    bus.load_en = 1'b1; bus.load_adrs = 32'h4; bus.load_data = 32'hFFFFFFFF;
    for (int i = 0; i < 10; i++) cyc();
    bus.load_en = 1'b0;
    wait_clear(n);
    chk("clear2_cycles", 64'(n), 64'(246));

    // Every word is NOP after the clear.
    bus.req_valid = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) begin
      bus.req_adrs = 32'(i * 4);
      cyc();
      expect_rsp("clr_word", 1, 32'h0, 32'(i * 4), 0);
    end
    bus.req_valid = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/inst_mem_sync.md
Name: inst_mem_sync

Overview:
- Parametrised, synchronous instruction memory for the pipelined CPU; replaces the combinational fetch ROM in the IF stage.
- Byte-addressed, word-aligned fetch with a 1-cycle registered read and valid/ready handshake.
- Supports IF-stage stall and branch-flush.
- Has a program-load write port so test programs are written at run time.
- Clears itself to NOP after reset.

Parameters:
- DATA_W, 32, instruction width in bits.
- DEPTH, 256, number of instruction words (power of two, ≥4).
- ADDR_W, 32, byte-address width of fetch and load addresses.
- NOP_WORD, 0, value written on clear and returned on any error.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  fetch request.
- req_adrs  in  ADDR_W  fetch byte address (PC).
- req_ready  out  1  fetch accepted when req_valid & req_ready.
- stall  in  1  IF stage frozen; hold response.
- flush  in  1  discard in-flight/held response (branch taken).
- rsp_valid  out  1  rsp_inst valid.
- rsp_inst  out  DATA_W  fetched instruction.
- rsp_adrs  out  ADDR_W  byte address of rsp_inst.
- rsp_err  out  1  misaligned or out-of-range fetch.
- load_en  in  1  program-load write strobe.
- load_adrs  in  ADDR_W  load byte address.
- load_data  in  DATA_W  word to store.
- load_ready  out  1  load accepted when load_en & load_ready.
- busy  out  1  clear in progress.

Behaviour:
- Reset: when rst is sampled high, state goes to CLEAR and clear counter resets to 0. On that clock edge the outputs become:
  - rsp_valid = 0, rsp_inst = NOP_WORD, rsp_adrs = 0, rsp_err = 0;
  - req_ready = 0, load_ready = 0, busy = 1.
- Reset mid-operation: the in-flight response is dropped and the clear restarts from word 0.
- Word index = adrs[log2(DEPTH)+1:2].
  - Misaligned: adrs[1:0] != 0.
  - Out of range: adrs[ADDR_W-1:log2(DEPTH)+2] != 0.
- FSM states:
  - CLEAR: write NOP_WORD to word cnt, one word per cycle, cnt++. After the word DEPTH-1 write, go to RUN. Takes exactly DEPTH cycles after reset deasserts. busy=1; req_ready=0; load_ready=0.
  - RUN: busy=0; load_ready=1; req_ready = ~stall & ~flush. There is no exit except rst.
- Fetch:
  - Request accepted at edge N → at edge N+1: rsp_valid=1, rsp_inst=mem[index], rsp_adrs=req_adrs.
  - Back-to-back requests give one response per cycle.
  - Error fetch: rsp_inst=NOP_WORD, rsp_err=1, memory not read.
- Stall: while stall=1, rsp_valid/inst/adrs/err hold their values and no new request is accepted.
- Flush:
  - Next edge: rsp_valid=0, rsp_err=0, rsp_inst=NOP_WORD.
  - Flush has priority over stall and over a same-cycle request; that request is not accepted.
- No request accepted and no stall: rsp_valid clears to 0 at the next edge.
- Load:
  - Accepted in RUN only; writes mem[index] at the edge.
  - Misaligned or out-of-range load: silently dropped, no memory change.
  - load_en while CLEAR is ignored.
- Same-cycle load and fetch to the same word: read-first; the response returns the old word, and the new word is visible from the next fetch.
- Memory read and write are both synchronous. Inference as block RAM must be possible: one write port, one read port.

Test Plan:
- rst 1 cycle, DEPTH=256: busy=1 for exactly 256 cycles, then req_ready=1. Fetch adrs 0x0, 0x4, 0x3FC → rsp_inst=0x00000000 each, err=0, rsp_valid one cycle after each accept.
- Load 0x80010608 at adrs 4 and 0x04011000 at adrs 8. Fetch 4 then 8 back-to-back → rsp 0x80010608 then 0x04011000 on consecutive cycles, rsp_adrs=4 then 8.
- After the response for adrs 4, stall=1 for 3 cycles with req_valid=1 → rsp holds 0x80010608/4 and req_ready=0. Release stall → next fetch accepted.
- Request 0xC with flush=1 the same cycle → not accepted, rsp_valid=0 next cycle. flush during a held stall → rsp_valid=0 next edge.
- Fetch adrs 0x6 → err=1, inst=0. Fetch adrs 0x400 → err=1, inst=0. Load to 0x400 → no memory change (fetch 0x0 still returns its prior value).
- Same-cycle load 0xDEADBEEF at adrs 0x10 and fetch 0x10 → returns old value. Re-fetch 0x10 → 0xDEADBEEF. Assert rst mid-stream → rsp_valid=0 next edge, busy=1, and all words read 0 after the clear.
